// File: rtl/clk_divider.sv
// -----------------------------------------------------------------------------
// clk_divider
// Free-running baud-tick generator. A counter runs 0..DIVISOR and wraps, and
// a registered one-clock enable pulse is produced once per DIVISOR+1 clocks.
//
// Ports:
//   clk_i     - system clock, rising edge
//   resetn_i  - synchronous active-low reset (counter and tick cleared)
//   clk_en_o  - one-clock tick, high while the counter equals DIVISOR
// -----------------------------------------------------------------------------
module clk_divider #(
    parameter int unsigned DIVISOR = 7
) (
    input  logic clk_i,
    input  logic resetn_i,
    output logic clk_en_o
);

    localparam logic [15:0] DIV = 16'(DIVISOR);

    logic [15:0] cnt_q, cnt_d;
    logic        tick_q, tick_d;

    always_comb begin
        cnt_d  = (cnt_q == DIV) ? 16'd0 : cnt_q + 16'd1;
        // Registered compare one count early, so the tick register is high
        // exactly during the cycle in which the counter holds DIVISOR.
        tick_d = (cnt_q == DIV - 16'd1);
    end

    // NOTE: sequential state uses non-blocking assignments only, and the reset
    // is synchronous: it is just the highest-priority branch under the clock.
    always_ff @(posedge clk_i) begin
        if (!resetn_i) begin
            cnt_q  <= 16'd0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tick_q <= tick_d;
        end
    end

    assign clk_en_o = tick_q;

endmodule

// File: rtl/uart_tx_op_top.sv
// -----------------------------------------------------------------------------
// uart_tx_op_top
// UART transmitter with integrated baud-tick generator. A one-cycle shoot_i in
// IDLE latches datain_i; the frame (start, 8 data LSB first, optional parity,
// stop) is then sent, one bit per baud tick, starting at the first tick after
// acceptance.
//
// Ports:
//   clk_i        - system clock, rising edge
//   resetn_i     - synchronous active-low reset; aborts any frame in flight
//   datain_i     - byte to send, sampled on the accepted shoot_i cycle
//   shoot_i      - single-cycle start request, ignored while busy
//   uart_tx_o    - registered serial line, idle high
//   uart_busy_o  - high from accept until the end of the stop bit
// -----------------------------------------------------------------------------
module uart_tx_op_top #(
    parameter int unsigned DIVISOR     = 7,
    parameter logic        VERIFY_ON   = 1'b1,
    parameter logic        VERIFY_EVEN = 1'b1
) (
    input  logic       clk_i,
    input  logic       resetn_i,
    input  logic [7:0] datain_i,
    input  logic       shoot_i,
    output logic       uart_tx_o,
    output logic       uart_busy_o
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_WAIT   = 3'd1,
        S_START  = 3'd2,
        S_DATA   = 3'd3,
        S_PARITY = 3'd4,
        S_STOP   = 3'd5
    } state_e;

    state_e     state_q;
    logic [7:0] shift_q;
    logic [2:0] bit_idx_q;
    logic       parity_q;
    logic       tx_q;
    logic       busy_q;
    logic       tick;

    clk_divider #(
        .DIVISOR (DIVISOR)
    ) u_div (
        .clk_i    (clk_i),
        .resetn_i (resetn_i),
        .clk_en_o (tick)
    );

    always_ff @(posedge clk_i) begin
        if (!resetn_i) begin
            state_q   <= S_IDLE;
            shift_q   <= 8'h00;
            bit_idx_q <= 3'd0;
            parity_q  <= 1'b0;
            tx_q      <= 1'b1;
            busy_q    <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    tx_q <= 1'b1;
                    // Acceptance ignores the tick: even a coincident tick
                    // only moves us to WAIT, the start bit waits for the next.
                    if (shoot_i) begin
                        shift_q  <= datain_i;
                        parity_q <= VERIFY_EVEN ? (^datain_i) : ~(^datain_i);
                        busy_q   <= 1'b1;
                        state_q  <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (tick) begin
                        tx_q    <= 1'b0;
                        state_q <= S_START;
                    end
                end
                S_START: begin
                    if (tick) begin
                        tx_q      <= shift_q[0];
                        shift_q   <= {1'b0, shift_q[7:1]};
                        bit_idx_q <= 3'd0;
                        state_q   <= S_DATA;
                    end
                end
                S_DATA: begin
                    // bit_idx_q counts data bits already on the line.
                    if (tick) begin
                        if (bit_idx_q == 3'd7) begin
                            if (VERIFY_ON) begin
                                tx_q    <= parity_q;
                                state_q <= S_PARITY;
                            end else begin
                                tx_q    <= 1'b1;
                                state_q <= S_STOP;
                            end
                        end else begin
                            tx_q      <= shift_q[0];
                            shift_q   <= {1'b0, shift_q[7:1]};
                            bit_idx_q <= bit_idx_q + 3'd1;
                        end
                    end
                end
                S_PARITY: begin
                    if (tick) begin
                        tx_q    <= 1'b1;
                        state_q <= S_STOP;
                    end
                end
                S_STOP: begin
                    if (tick) begin
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end
                end
                default: begin
                    tx_q    <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign uart_tx_o   = tx_q;
    assign uart_busy_o = busy_q;

endmodule

// File: tb/tb_uart_tx_op_top.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_op_top
// Three transmitters share one stimulus: even parity, odd parity, and no
// parity, all with DIVISOR=7 (8 clocks per bit). Expected frames are pushed to
// a scoreboard queue when a byte is shot and popped by the frame monitors.
// -----------------------------------------------------------------------------
module tb_uart_tx_op_top;

    localparam int BIT_CLKS = 8;

    logic       clk = 1'b0;
    logic       resetn;
    logic [7:0] datain;
    logic       shoot;
    logic [2:0] tx_w;
    logic [2:0] busy_w;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    uart_tx_op_top #(.DIVISOR(7), .VERIFY_ON(1'b1), .VERIFY_EVEN(1'b1)) dut0 (
        .clk_i(clk), .resetn_i(resetn), .datain_i(datain), .shoot_i(shoot),
        .uart_tx_o(tx_w[0]), .uart_busy_o(busy_w[0]));

    uart_tx_op_top #(.DIVISOR(7), .VERIFY_ON(1'b1), .VERIFY_EVEN(1'b0)) dut1 (
        .clk_i(clk), .resetn_i(resetn), .datain_i(datain), .shoot_i(shoot),
        .uart_tx_o(tx_w[1]), .uart_busy_o(busy_w[1]));

    uart_tx_op_top #(.DIVISOR(7), .VERIFY_ON(1'b0), .VERIFY_EVEN(1'b1)) dut2 (
        .clk_i(clk), .resetn_i(resetn), .datain_i(datain), .shoot_i(shoot),
        .uart_tx_o(tx_w[2]), .uart_busy_o(busy_w[2]));

    typedef struct {
        logic [7:0] data;
        logic       par_even;   // hand-derived parity bits
        logic       par_odd;
    } vec_t;

    typedef struct {
        logic [10:0] bits [3];
        int          nbits [3];
    } frame_t;

    frame_t exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [10:0] mk_frame(input logic [7:0] d, input logic par, input logic has_par);
        logic [10:0] f;
        f[0]   = 1'b0;
        f[8:1] = d;
        f[9]   = has_par ? par : 1'b1;
        f[10]  = 1'b1;
        return f;
    endfunction

    // Push the expected frames, pulse shoot_i for one cycle, check busy rises.
    task automatic send_byte(input logic [7:0] d, input logic pe, input logic po);
        frame_t fr;
        fr.bits[0]  = mk_frame(d, pe, 1'b1);
        fr.bits[1]  = mk_frame(d, po, 1'b1);
        fr.bits[2]  = mk_frame(d, 1'b0, 1'b0);
        fr.nbits[0] = 11;
        fr.nbits[1] = 11;
        fr.nbits[2] = 10;
        exp_q.push_back(fr);
        datain = d;
        shoot  = 1'b1;
        @(negedge clk);
        shoot  = 1'b0;
        check($sformatf("busy_rise_%02h", d), {29'd0, busy_w}, 32'h7);
    endtask

    // Follow one transmitter through a frame: line high until the start bit,
    // then every bit held BIT_CLKS samples with busy high, then busy low.
    task automatic check_frame(input int idx, input logic [10:0] bits, input int nbits);
        int   waited;
        logic act;
        waited = 0;
        while (tx_w[idx] !== 1'b0 && waited < BIT_CLKS + 2) begin
            @(negedge clk);
            waited++;
        end
        check($sformatf("start_seen_%0d", idx), {31'd0, tx_w[idx]}, 32'd0);
        if (tx_w[idx] !== 1'b0) return;
        for (int b = 0; b < nbits; b++) begin
            act = bits[b];
            for (int s = 0; s < BIT_CLKS; s++) begin
                if (b != 0 || s != 0) @(negedge clk);
                if (act === bits[b] && (tx_w[idx] !== bits[b] || busy_w[idx] !== 1'b1))
                    act = ~bits[b];
            end
            check($sformatf("dut%0d_bit%0d", idx, b), {31'd0, act}, {31'd0, bits[b]});
        end
        @(negedge clk);
        check($sformatf("dut%0d_busy_fall", idx), {31'd0, busy_w[idx]}, 32'd0);
        check($sformatf("dut%0d_line_idle", idx), {31'd0, tx_w[idx]}, 32'd1);
    endtask

    task automatic run_frame();
        frame_t fr;
        if (exp_q.size() == 0) begin
            check("scoreboard_empty", 32'd1, 32'd0);
            return;
        end
        fr = exp_q.pop_front();
        fork
            check_frame(0, fr.bits[0], fr.nbits[0]);
            check_frame(1, fr.bits[1], fr.nbits[1]);
            check_frame(2, fr.bits[2], fr.nbits[2]);
        join
    endtask

    vec_t vecs [6];

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int   gap;
        logic quiet;

        // 4F: five ones; 00/FF: even count; A5: four; 7E: six; 01: one.
        vecs[0] = '{8'h4F, 1'b1, 1'b0};
        vecs[1] = '{8'h00, 1'b0, 1'b1};
        vecs[2] = '{8'hFF, 1'b0, 1'b1};
        vecs[3] = '{8'hA5, 1'b0, 1'b1};
        vecs[4] = '{8'h7E, 1'b0, 1'b1};
        vecs[5] = '{8'h01, 1'b1, 1'b0};

        resetn = 1'b0;
        shoot  = 1'b0;
        datain = 8'h00;
        @(negedge clk);
        check("reset_tx", {29'd0, tx_w}, 32'h7);
        check("reset_busy", {29'd0, busy_w}, 32'h0);
        resetn = 1'b1;
        @(negedge clk);
        check("post_reset_tx", {29'd0, tx_w}, 32'h7);
        check("post_reset_busy", {29'd0, busy_w}, 32'h0);

        // Tick period measured on the divider enable.
        for (int k = 0; k < 2; k++) begin
            gap = 0;
            while (dut0.u_div.clk_en_o !== 1'b1 && gap < 20) begin
                @(negedge clk);
                gap++;
            end
            gap = 0;
            do begin
                @(negedge clk);
                gap++;
            end while (dut0.u_div.clk_en_o !== 1'b1 && gap < 20);
            check($sformatf("tick_period_%0d", k), gap, BIT_CLKS);
        end

        // Table-driven frames, each shot the cycle after the previous busy fall.
        for (int v = 0; v < 6; v++) begin
            send_byte(vecs[v].data, vecs[v].par_even, vecs[v].par_odd);
            run_frame();
        end

        // Shoot during a frame is ignored: 4F completes, no AA frame follows.
        send_byte(8'h4F, 1'b1, 1'b0);
        fork
            run_frame();
            begin
                repeat (30) @(negedge clk);
                datain = 8'hAA;
                shoot  = 1'b1;
                @(negedge clk);
                shoot  = 1'b0;
            end
        join
        quiet = 1'b1;
        for (int c = 0; c < 4 * BIT_CLKS; c++) begin
            @(negedge clk);
            if (tx_w !== 3'b111 || busy_w !== 3'b000) quiet = 1'b0;
        end
        check("no_frame_after_ignored_shoot", {31'd0, quiet}, 32'd1);

        // Reset during data bit 3 aborts at the next edge.
        datain = 8'h4F;
        shoot  = 1'b1;
        @(negedge clk);
        shoot  = 1'b0;
        gap = 0;
        while (tx_w[0] !== 1'b0 && gap < BIT_CLKS + 2) begin
            @(negedge clk);
            gap++;
        end
        check("abort_start_seen", {31'd0, tx_w[0]}, 32'd0);
        repeat (4 * BIT_CLKS + 2) @(negedge clk);
        check("abort_in_bit3", {31'd0, tx_w[0]}, 32'd1);
        resetn = 1'b0;
        @(negedge clk);
        check("abort_tx", {29'd0, tx_w}, 32'h7);
        check("abort_busy", {29'd0, busy_w}, 32'h0);
        resetn = 1'b1;
        @(negedge clk);

        // Clean frame after the abort: 3C has four ones.
        send_byte(8'h3C, 1'b0, 1'b1);
        run_frame();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_tx_op_top.md
Name:
uart_tx_op_top

Overview:
UART transmitter with an integrated baud-tick generator. The transmitter accepts a byte on a one-cycle shoot pulse and serialises it. The frame is start bit, 8 data bits LSB first, an optional parity bit, and a stop bit. Each bit lasts one baud tick, and the tick is derived from the system clock. It sits at the edge of the design and drives the board-level UART TX pin.

Parameters:
DIVISOR, 7, tick period is DIVISOR+1 clk cycles (default 8 cycles); legal range 1..65535
VERIFY_ON, 1'b1, 1 = insert parity bit between data and stop; 0 = no parity bit
VERIFY_EVEN, 1'b1, 1 = even parity (parity bit = XOR of data bits); 0 = odd parity (inverted XOR)

Ports:
clk_i  input  1  system clock, all logic on rising edge
resetn_i  input  1  synchronous, active-low reset
datain_i  input  8  byte to send, sampled on the accepted shoot_i cycle
shoot_i  input  1  start request, single-cycle pulse
uart_tx_o  output  1  serial line, idle high
uart_busy_o  output  1  high from accept until frame end

Behaviour:
- Reset (resetn_i low at a rising edge):
  - uart_tx_o=1, uart_busy_o=0.
  - Divider counter=0, tick=0, FSM=IDLE.
  - Reset mid-frame aborts immediately; the line returns high on the next edge.
- Divider:
  - Counter runs 0..DIVISOR and wraps to 0.
  - tick is registered and high for exactly one clk when the counter equals DIVISOR, so the period is DIVISOR+1 cycles.
  - Free-running; not synchronised to shoot_i.
- Accept:
  - In IDLE, shoot_i=1 at a rising edge latches datain_i into the shift register.
  - uart_busy_o goes 1 on that same edge, registered, so it is visible the next cycle.
  - Acceptance does not wait for a tick.
  - shoot_i while busy is ignored; data is not re-latched.
- FSM states: IDLE -> WAIT -> START -> DATA (8 bits) -> PARITY (only if VERIFY_ON) -> STOP -> IDLE.
  - All transitions after WAIT occur only on tick cycles.
  - WAIT: line held high until the first tick.
  - On that tick: uart_tx_o=0, enter START.
  - Each following tick advances one bit.
  - DATA outputs bit0 first through bit7; a 3-bit index counts 0..7.
  - PARITY outputs ^data when VERIFY_EVEN=1, else ~^data.
  - STOP outputs 1.
  - The tick after STOP's full bit period returns to IDLE and clears uart_busy_o on that edge.
- Line and busy timing:
  - Every bit is held exactly DIVISOR+1 clks.
  - uart_tx_o is registered (glitch-free) and stays high throughout IDLE and WAIT.
  - Busy duration is the accept-to-first-tick latency (1..DIVISOR+1 clks) plus 11 bit periods (10 when VERIFY_ON=0).
  - Busy falls at the end of the stop bit.
- Simultaneous events:
  - shoot_i on the same edge busy falls: ignored, because the FSM is not yet IDLE on that edge.
  - shoot_i on the following cycle: accepted.
  - shoot_i coinciding with a tick while IDLE: accepted into WAIT; the start bit begins at the next tick, not this one.

Decomposition:
- No shared package needed.
- Local FSM state encoding (IDLE, WAIT, START, DATA, PARITY, STOP) lives as localparams in uart_tx_op_top.
- One natural sub-module: clk_divider, with parameter DIVISOR and ports clk_i, resetn_i, clk_en_o.
  - It produces the one-cycle tick and is instantiated once.
  - Its reset behaviour matches the top level.
- Shift/parity/FSM logic stays in the top.

Test Plan:
1. Reset: hold resetn_i low 1 cycle, then release.
   - uart_tx_o=1 and uart_busy_o=0 during and after reset.
   - tick pulses every 8 clks with DIVISOR=7.
2. Single byte 8'h4F, even parity, DIVISOR=7, shoot_i pulsed one cycle after reset:
   - busy rises the next cycle.
   - Line after first tick: 0 | 1,1,1,1,0,0,1,0 | 1 (parity, 5 ones) | 1, each held 8 clks.
   - busy falls 88 clks after the start bit began.
3. VERIFY_EVEN=0 with 8'h4F:
   - Parity bit = 0; rest of frame identical.
   - VERIFY_ON=0: frame 10 bits with no parity; busy 8 clks shorter.
4. shoot_i with datain_i=8'hAA pulsed mid-frame of 8'h4F:
   - Ignored; the 8'h4F frame completes unchanged and no second frame follows.
5. Back-to-back: 8'h00 then 8'hFF, second shoot_i issued the cycle after busy falls:
   - Two frames, parity 0 then 0 (even).
   - Line stays high between frames until the next tick.
6. Reset asserted during data bit 3:
   - Next edge: uart_tx_o=1, busy=0.
   - A new shoot_i after release sends a clean full frame.
